// File: rtl/inst_pc_queue_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction/PC queue.
package inst_pc_queue_pkg;

  localparam int MAX_LANES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } inst_pc_entry_t;

  // Counts the contiguous run of ones starting at bit 0; anything after the first zero is ignored.
  function automatic logic [2:0] lead_ones(input logic [MAX_LANES-1:0] vec);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & vec[i];
      n   = n + {2'b00, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_pc_queue_ptr_ctrl.sv
// Pointer, occupancy and flow-control bookkeeping for inst_pc_queue.
module queue_ptr_ctrl
  import inst_pc_queue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1),
  parameter int PTRW  = $clog2(DEPTH),
  parameter int DCW   = $clog2(LANES + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic [DCW-1:0]  i_push_req,
  input  logic [DCW-1:0]  i_deq_cnt,
  output logic [DCW-1:0]  o_push_n,
  output logic [PTRW-1:0] o_rd_ptr,
  output logic [PTRW-1:0] o_wr_ptr,
  output logic [CNTW-1:0] o_count,
  output logic            o_in_ready,
  output logic            o_err_underflow
);

  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_err;

  logic            w_ready;
  logic [CNTW-1:0] w_push_n;
  logic [CNTW-1:0] w_avail;
  logic [CNTW-1:0] w_deq;
  logic            w_under;
  logic [CNTW-1:0] w_pop_n;

  // Credit comes only from the registered count, so a same-cycle pop never frees a slot.
  assign w_ready  = (r_count <= CNTW'(DEPTH - LANES));
  assign w_push_n = (w_ready && !i_flush) ? CNTW'(i_push_req) : '0;
  assign w_avail  = (r_count < CNTW'(LANES)) ? r_count : CNTW'(LANES);
  assign w_deq    = CNTW'(i_deq_cnt);
  assign w_under  = (w_deq > w_avail);
  assign w_pop_n  = w_under ? w_avail : w_deq;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTRW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PTRW'(w_push_n);
      r_count  <= r_count + w_push_n - w_pop_n;
      r_err    <= w_under;
    end
  end

  assign o_push_n        = DCW'(w_push_n);
  assign o_rd_ptr        = r_rd_ptr;
  assign o_wr_ptr        = r_wr_ptr;
  assign o_count         = r_count;
  assign o_in_ready      = w_ready;
  assign o_err_underflow = r_err;

endmodule

// File: rtl/inst_pc_queue.sv
// N-lane in-order instruction/PC circular buffer between fetch and decode.
module inst_pc_queue
  import inst_pc_queue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*32-1:0]        in_pc,
  input  logic [LANES*32-1:0]        in_instr,
  output logic                       in_ready,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*32-1:0]        out_pc,
  output logic [LANES*32-1:0]        out_instr,
  input  logic [$clog2(LANES+1)-1:0] deq_cnt,
  output logic [CNTW-1:0]            occupancy,
  output logic                       err_underflow
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int DCW  = $clog2(LANES + 1);

  inst_pc_entry_t  r_mem [DEPTH];

  logic [DCW-1:0]  w_push_req;
  logic [DCW-1:0]  w_push_n;
  logic [PTRW-1:0] w_rd_ptr;
  logic [PTRW-1:0] w_wr_ptr;
  logic [CNTW-1:0] w_count;

  assign w_push_req = DCW'(lead_ones(MAX_LANES'(in_valid)));

  queue_ptr_ctrl #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .CNTW  (CNTW),
    .PTRW  (PTRW),
    .DCW   (DCW)
  ) u_ptr_ctrl (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_flush         (flush),
    .i_push_req      (w_push_req),
    .i_deq_cnt       (deq_cnt),
    .o_push_n        (w_push_n),
    .o_rd_ptr        (w_rd_ptr),
    .o_wr_ptr        (w_wr_ptr),
    .o_count         (w_count),
    .o_in_ready      (in_ready),
    .o_err_underflow (err_underflow)
  );

  // Storage carries data only; w_push_n is already zero when refused or flushed.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (DCW'(j) < w_push_n) begin
        r_mem[w_wr_ptr + PTRW'(j)] <= '{pc: in_pc[32*j +: 32], instr: in_instr[32*j +: 32]};
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_count > CNTW'(i)) begin
        out_valid[i]         = 1'b1;
        out_pc[32*i +: 32]    = r_mem[w_rd_ptr + PTRW'(i)].pc;
        out_instr[32*i +: 32] = r_mem[w_rd_ptr + PTRW'(i)].instr;
      end
    end
  end

  assign occupancy = w_count;

endmodule
